// File: rtl/uart_buffered_core_pkg.sv
// Shared definitions for the buffered UART: FSM state encoding, oversampling constants
// and the frame parity helper.
package uart_buffered_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE   = 16;
    localparam int START_CENTRE = 7;

    // Narrower data words are zero-extended by the caller, which leaves parity unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data; full/empty come from the
// extra pointer MSB. Read data is forced to zero while empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_wr_s;
    logic             do_rd_s;

    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign do_rd_s = rd_en && !empty;
    // A push into a full FIFO still lands when the head is popped in the same cycle.
    assign do_wr_s = wr_en && (!full || do_rd_s);
    assign rd_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_wr_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            if (do_rd_s) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_wr_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_buffered_core.sv
// Buffered UART transceiver with 16x oversampling tick, TX/RX FIFOs and configurable frame.
// Define UART_PARITY_EN to add a parity bit (and the parity_error port).
module uart_buffered_core #(
    parameter int BAUD_DIV   = 326,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 tx_write,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data_out,
    input  logic                 rx_read,
    output logic                 rx_empty,
    output logic                 rx_overrun,
    input  logic                 rx_overrun_clear,
    output logic                 frame_error
`ifdef UART_PARITY_EN
    ,
    output logic                 parity_error
`endif
);
    import uart_buffered_core_pkg::*;

    localparam int          TW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [4:0]  BIT_END   = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]  START_END = 5'(START_CENTRE);
    localparam logic [4:0]  STOP_END  = 5'(OVERSAMPLE * STOP_BITS - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
    localparam uart_state_t AFTER_DATA = ST_PARITY;
`else
    localparam uart_state_t AFTER_DATA = ST_STOP;
`endif

    logic [TW-1:0]        tick_cnt_r;
    logic                 tick_s;
    logic [1:0]           rx_sync_r;
    logic                 rx_in_s;
    uart_state_t          rx_state_r, rx_state_n;
    logic [4:0]           rx_scnt_r, rx_scnt_n;
    logic [2:0]           rx_ncnt_r, rx_ncnt_n;
    logic [DATA_BITS-1:0] rx_data_r, rx_data_n;
    logic                 rx_push_s, rx_ferr_s, rx_full_s, ovr_set_s;
    uart_state_t          tx_state_r, tx_state_n;
    logic [4:0]           tx_scnt_r, tx_scnt_n;
    logic [2:0]           tx_ncnt_r, tx_ncnt_n;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_n, tx_head_s;
    logic                 tx_pop_s, tx_empty_s, tx_s, tx_r;
    logic                 frame_error_r, overrun_r;
`ifdef UART_PARITY_EN
    logic                 rx_par_r, rx_par_n, rx_perr_s, parity_error_r;
    logic                 tx_par_r, tx_par_n;
`endif

    assign tick_s      = (tick_cnt_r == TW'(BAUD_DIV - 1));
    assign rx_in_s     = rx_sync_r[1];
    assign tx          = tx_r;
    assign tx_busy     = (tx_state_r != ST_IDLE) || !tx_empty_s;
    assign frame_error = frame_error_r;
    assign rx_overrun  = overrun_r;
    assign ovr_set_s   = rx_push_s && rx_full_s && !rx_read;
`ifdef UART_PARITY_EN
    assign parity_error = parity_error_r;
`endif

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .wr_en(tx_write), .wr_data(tx_data_in),
        .rd_en(tx_pop_s), .rd_data(tx_head_s), .full(tx_full), .empty(tx_empty_s)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .wr_en(rx_push_s), .wr_data(rx_data_r),
        .rd_en(rx_read), .rd_data(rx_data_out), .full(rx_full_s), .empty(rx_empty)
    );

    // Free-running oversample tick and two-stage rx synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= {TW{1'b0}};
            rx_sync_r  <= 2'b11;
        end else begin
            tick_cnt_r <= tick_s ? {TW{1'b0}} : tick_cnt_r + TW'(1);
            rx_sync_r  <= {rx_sync_r[0], rx};
        end
    end

    // RX next-state: centre-sample each bit and classify the frame at the stop bit.
    always_comb begin
        rx_state_n = rx_state_r;
        rx_scnt_n  = rx_scnt_r;
        rx_ncnt_n  = rx_ncnt_r;
        rx_data_n  = rx_data_r;
        rx_push_s  = 1'b0;
        rx_ferr_s  = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_n   = rx_par_r;
        rx_perr_s  = 1'b0;
`endif
        case (rx_state_r)
            ST_IDLE: begin
                rx_scnt_n = 5'd0;
                if (!rx_in_s) rx_state_n = ST_START;
                else          rx_state_n = ST_IDLE;
            end
            ST_START: begin
                if (tick_s && (rx_scnt_r == START_END)) begin
                    rx_scnt_n = 5'd0;
                    rx_ncnt_n = 3'd0;
                    if (rx_in_s) rx_state_n = ST_IDLE;
                    else         rx_state_n = ST_DATA;
                end else if (tick_s) begin
                    rx_scnt_n = rx_scnt_r + 5'd1;
                end else begin
                    rx_scnt_n = rx_scnt_r;
                end
            end
            ST_DATA: begin
                if (tick_s && (rx_scnt_r == BIT_END)) begin
                    rx_scnt_n = 5'd0;
                    rx_data_n = {rx_in_s, rx_data_r[DATA_BITS-1:1]};
                    if (rx_ncnt_r == LAST_BIT) rx_state_n = AFTER_DATA;
                    else                       rx_ncnt_n  = rx_ncnt_r + 3'd1;
                end else if (tick_s) begin
                    rx_scnt_n = rx_scnt_r + 5'd1;
                end else begin
                    rx_scnt_n = rx_scnt_r;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tick_s && (rx_scnt_r == BIT_END)) begin
                    rx_scnt_n  = 5'd0;
                    rx_par_n   = rx_in_s;
                    rx_state_n = ST_STOP;
                end else if (tick_s) begin
                    rx_scnt_n = rx_scnt_r + 5'd1;
                end else begin
                    rx_scnt_n = rx_scnt_r;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s && (rx_scnt_r == BIT_END)) begin
                    rx_scnt_n  = 5'd0;
                    rx_state_n = ST_IDLE;
                    if (!rx_in_s) begin
                        rx_ferr_s = 1'b1;
`ifdef UART_PARITY_EN
                    end else if (calc_parity(8'(rx_data_r), PARITY_ODD != 0) != rx_par_r) begin
                        rx_perr_s = 1'b1;
`endif
                    end else begin
                        rx_push_s = 1'b1;
                    end
                end else if (tick_s) begin
                    rx_scnt_n = rx_scnt_r + 5'd1;
                end else begin
                    rx_scnt_n = rx_scnt_r;
                end
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

    // TX next-state: pop the FIFO head whenever a frame can start, shift LSB first.
    always_comb begin
        tx_state_n = tx_state_r;
        tx_scnt_n  = tx_scnt_r;
        tx_ncnt_n  = tx_ncnt_r;
        tx_shift_n = tx_shift_r;
        tx_pop_s   = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par_r;
`endif
        case (tx_state_r)
            ST_IDLE: begin
                tx_scnt_n = 5'd0;
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_state_n = ST_START;
                end else begin
                    tx_state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (tx_scnt_r == BIT_END)) begin
                    tx_scnt_n  = 5'd0;
                    tx_ncnt_n  = 3'd0;
                    tx_state_n = ST_DATA;
                end else if (tick_s) begin
                    tx_scnt_n = tx_scnt_r + 5'd1;
                end else begin
                    tx_scnt_n = tx_scnt_r;
                end
            end
            ST_DATA: begin
                if (tick_s && (tx_scnt_r == BIT_END)) begin
                    tx_scnt_n = 5'd0;
                    if (tx_ncnt_r == LAST_BIT) begin
                        tx_state_n = AFTER_DATA;
                    end else begin
                        tx_ncnt_n  = tx_ncnt_r + 3'd1;
                        tx_shift_n = tx_shift_r >> 1;
                    end
                end else if (tick_s) begin
                    tx_scnt_n = tx_scnt_r + 5'd1;
                end else begin
                    tx_scnt_n = tx_scnt_r;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tick_s && (tx_scnt_r == BIT_END)) begin
                    tx_scnt_n  = 5'd0;
                    tx_state_n = ST_STOP;
                end else if (tick_s) begin
                    tx_scnt_n = tx_scnt_r + 5'd1;
                end else begin
                    tx_scnt_n = tx_scnt_r;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s && (tx_scnt_r == STOP_END)) begin
                    // Chain straight into the next start bit so queued bytes leave without a gap.
                    tx_scnt_n = 5'd0;
                    if (!tx_empty_s) begin
                        tx_pop_s   = 1'b1;
                        tx_state_n = ST_START;
                    end else begin
                        tx_state_n = ST_IDLE;
                    end
                end else if (tick_s) begin
                    tx_scnt_n = tx_scnt_r + 5'd1;
                end else begin
                    tx_scnt_n = tx_scnt_r;
                end
            end
            default: tx_state_n = ST_IDLE;
        endcase

        if (tx_pop_s) begin
            tx_shift_n = tx_head_s;
`ifdef UART_PARITY_EN
            tx_par_n   = calc_parity(8'(tx_head_s), PARITY_ODD != 0);
`endif
        end else begin
            tx_shift_n = tx_shift_n;
        end

        case (tx_state_n)
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = tx_shift_n[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_s = tx_par_n;
`endif
            default:   tx_s = 1'b1;
        endcase
    end

    // FSM, counter and shift registers for both directions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_r <= ST_IDLE;
            rx_scnt_r  <= 5'd0;
            rx_ncnt_r  <= 3'd0;
            rx_data_r  <= {DATA_BITS{1'b0}};
            tx_state_r <= ST_IDLE;
            tx_scnt_r  <= 5'd0;
            tx_ncnt_r  <= 3'd0;
            tx_shift_r <= {DATA_BITS{1'b0}};
            tx_r       <= 1'b1;
`ifdef UART_PARITY_EN
            rx_par_r   <= 1'b0;
            tx_par_r   <= 1'b0;
`endif
        end else begin
            rx_state_r <= rx_state_n;
            rx_scnt_r  <= rx_scnt_n;
            rx_ncnt_r  <= rx_ncnt_n;
            rx_data_r  <= rx_data_n;
            tx_state_r <= tx_state_n;
            tx_scnt_r  <= tx_scnt_n;
            tx_ncnt_r  <= tx_ncnt_n;
            tx_shift_r <= tx_shift_n;
            tx_r       <= tx_s;
`ifdef UART_PARITY_EN
            rx_par_r   <= rx_par_n;
            tx_par_r   <= tx_par_n;
`endif
        end
    end

    // Registered status: error pulses and sticky overrun (a new overrun beats a clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_error_r  <= 1'b0;
            overrun_r      <= 1'b0;
`ifdef UART_PARITY_EN
            parity_error_r <= 1'b0;
`endif
        end else begin
            frame_error_r <= rx_ferr_s;
            if (ovr_set_s)             overrun_r <= 1'b1;
            else if (rx_overrun_clear) overrun_r <= 1'b0;
            else                       overrun_r <= overrun_r;
`ifdef UART_PARITY_EN
            parity_error_r <= rx_perr_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart_buffered_core.sv
// Self-checking bench for uart_buffered_core: loopback and hand-driven rx frames,
// compared against a byte-queue model of what the link should deliver.
module tb_uart_buffered_core;
    localparam int BAUD_DIV   = 2;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 16;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CLKS   = 16 * BAUD_DIV;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLKS = NBITS * BIT_CLKS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx;
    logic [7:0] tx_data_in = 8'h00;
    logic       tx_write = 1'b0;
    logic       tx_full, tx_busy;
    logic [7:0] rx_data_out;
    logic       rx_read = 1'b0;
    logic       rx_empty, rx_overrun;
    logic       rx_overrun_clear = 1'b0;
    logic       frame_error;
    logic       loop_en = 1'b1;
    logic       drv_rx = 1'b1;
    logic       rx_pin;
`ifdef UART_PARITY_EN
    logic       parity_error;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    logic [7:0] exp_q[$];

    assign rx_pin = loop_en ? tx : drv_rx;

    always #5 clk = ~clk;

    uart_buffered_core #(
        .BAUD_DIV(BAUD_DIV), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS),
        .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx_pin), .tx(tx),
        .tx_data_in(tx_data_in), .tx_write(tx_write), .tx_full(tx_full), .tx_busy(tx_busy),
        .rx_data_out(rx_data_out), .rx_read(rx_read), .rx_empty(rx_empty),
        .rx_overrun(rx_overrun), .rx_overrun_clear(rx_overrun_clear),
        .frame_error(frame_error)
`ifdef UART_PARITY_EN
        , .parity_error(parity_error)
`endif
    );

    // Count error-pulse cycles away from the active edge.
    always @(negedge clk) begin
        if (frame_error === 1'b1) ferr_cnt++;
`ifdef UART_PARITY_EN
        if (parity_error === 1'b1) perr_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_bytes(input int n, input int keep);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(0, 255));
            tx_data_in = d;
            tx_write = 1'b1;
            if (i < keep) exp_q.push_back(d);
            clks(1);
        end
        tx_write = 1'b0;
    endtask

    task automatic pop_expect(input string tag);
        int waited;
        logic [7:0] e;
        waited = 0;
        while (rx_empty && waited < 2 * FRAME_CLKS + 100) begin
            clks(1);
            waited++;
        end
        e = exp_q.pop_front();
        check({tag, "_avail"}, {31'd0, rx_empty}, 32'd0);
        if (!rx_empty) begin
            check({tag, "_data"}, {24'd0, rx_data_out}, {24'd0, e});
            rx_read = 1'b1;
            clks(1);
            rx_read = 1'b0;
        end
    endtask

    task automatic wait_tx_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (tx_busy && n < bound) begin
            clks(1);
            n++;
        end
        check(tag, {31'd0, tx_busy}, 32'd0);
    endtask

    function automatic logic [11:0] make_frame(input logic [7:0] d, input logic stop_bit);
        logic [11:0] f;
        f = 12'hFFF;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef UART_PARITY_EN
        f[9]  = (^d) ^ (PARITY_ODD != 0);
        f[10] = stop_bit;
`else
        f[9]  = stop_bit;
`endif
        return f;
    endfunction

    task automatic drive_bits(input logic [11:0] f, input int last_len);
        for (int i = 0; i < NBITS; i++) begin
            drv_rx = f[i];
            clks((i == NBITS - 1) ? last_len : BIT_CLKS);
        end
        drv_rx = 1'b1;
    endtask

    initial begin
        logic [7:0] t1 [3];
        logic [7:0] d;
        int n;
        t1 = '{8'h0F, 8'hA5, 8'h3C};

        // Reset state
        clks(3);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_tx_full", {31'd0, tx_full}, 32'd0);
        check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data_out}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        reset = 1'b0;
        clks(5);

        // 1: three bytes back to back, total line time and loopback order
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tx_data_in = t1[i];
            tx_write = 1'b1;
            exp_q.push_back(t1[i]);
            clks(1);
            if (i == 1) check("t1_start_low", {31'd0, tx}, 32'd0);
            if (i == 1) check("t1_busy", {31'd0, tx_busy}, 32'd1);
        end
        tx_write = 1'b0;
        n = 1;
        while (tx_busy && n < 4 * FRAME_CLKS) begin
            clks(1);
            n++;
        end
        check("t1_three_frames_clks", {31'd0, (n == 3 * FRAME_CLKS - 1) || (n == 3 * FRAME_CLKS)}, 32'd1);
        check("t1_tx_idle_high", {31'd0, tx}, 32'd1);
        for (int i = 0; i < 3; i++) pop_expect("t1_rx");

        // 2: 18 writes; 17 accepted (one goes straight to the shifter), 18th dropped
        for (int i = 0; i < 18; i++) begin
            d = 8'($urandom_range(0, 255));
            tx_data_in = d;
            tx_write = 1'b1;
            if (i < 17) exp_q.push_back(d);
            clks(1);
            if (i == 1)  check("t2_first_popped", {31'd0, tx}, 32'd0);
            if (i == 15) check("t2_not_full_16", {31'd0, tx_full}, 32'd0);
            if (i == 16) check("t2_full_17", {31'd0, tx_full}, 32'd1);
        end
        tx_write = 1'b0;
        for (int i = 0; i < 17; i++) pop_expect("t2_rx");
        wait_tx_idle("t2_tx_idle", 2 * FRAME_CLKS);
        check("t2_rx_empty", {31'd0, rx_empty}, 32'd1);
        check("t2_no_overrun", {31'd0, rx_overrun}, 32'd0);

        // 3: 17 random bytes looped with no reads: 16 kept, overrun set then cleared
        write_bytes(17, 16);
        wait_tx_idle("t3_tx_idle", 18 * FRAME_CLKS);
        clks(40);
        check("t3_overrun_set", {31'd0, rx_overrun}, 32'd1);
        for (int i = 0; i < 16; i++) pop_expect("t3_rx");
        check("t3_rx_empty", {31'd0, rx_empty}, 32'd1);
        rx_overrun_clear = 1'b1;
        clks(1);
        rx_overrun_clear = 1'b0;
        check("t3_overrun_clr", {31'd0, rx_overrun}, 32'd0);

        // 4: frame 0x55 with stop low, then a good random frame
        loop_en = 1'b0;
        clks(10);
        drive_bits(make_frame(8'h55, 1'b0), 24);
        clks(200);
        check("t4_ferr_once", ferr_cnt, 32'd1);
        check("t4_rx_empty", {31'd0, rx_empty}, 32'd1);
        d = 8'($urandom_range(0, 255));
        exp_q.push_back(d);
        drive_bits(make_frame(d, 1'b1), BIT_CLKS);
        pop_expect("t4_good");

        // 5: 4-tick low glitch is ignored
        drv_rx = 1'b0;
        clks(4 * BAUD_DIV);
        drv_rx = 1'b1;
        clks(200);
        check("t5_rx_empty", {31'd0, rx_empty}, 32'd1);
        check("t5_no_ferr", ferr_cnt, 32'd1);
        check("t5_no_perr", perr_cnt, 32'd0);
        d = 8'($urandom_range(0, 255));
        exp_q.push_back(d);
        drive_bits(make_frame(d, 1'b1), BIT_CLKS);
        pop_expect("t5_good");

`ifdef UART_PARITY_EN
        // Corrupted parity bit: error pulse, byte dropped
        d = 8'($urandom_range(0, 255));
        begin
            logic [11:0] f;
            f = make_frame(d, 1'b1);
            f[9] = ~f[9];
            drive_bits(f, BIT_CLKS);
        end
        clks(100);
        check("tp_perr_once", perr_cnt, 32'd1);
        check("tp_rx_empty", {31'd0, rx_empty}, 32'd1);
        check("tp_no_ferr", ferr_cnt, 32'd1);
`endif

        // 6: reset in the middle of a transmitted frame
        loop_en = 1'b1;
        clks(10);
        write_bytes(2, 0);
        clks(100);
        reset = 1'b1;
        #1;
        check("t6_tx_high", {31'd0, tx}, 32'd1);
        check("t6_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("t6_tx_full", {31'd0, tx_full}, 32'd0);
        check("t6_rx_empty", {31'd0, rx_empty}, 32'd1);
        clks(3);
        reset = 1'b0;
        clks(2 * FRAME_CLKS);
        check("t6_no_rx_after", {31'd0, rx_empty}, 32'd1);
        check("t6_idle_after", {31'd0, tx_busy}, 32'd0);
        check("t6_tx_line", {31'd0, tx}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
